// File: rtl/sass_pkg.sv
// rtl/sass_pkg.sv - shared note codes, widths and playback state type for the sequencer track
package sass_pkg;

    localparam int NOTE_W = 4;

    typedef logic [NOTE_W-1:0] note_t;

    localparam note_t OFF     = 4'd0;
    localparam note_t LOW_C   = 4'd1;
    localparam note_t C_SHARP = 4'd2;
    localparam note_t D       = 4'd3;
    localparam note_t D_SHARP = 4'd4;
    localparam note_t E       = 4'd5;
    localparam note_t F       = 4'd6;
    localparam note_t F_SHARP = 4'd7;
    localparam note_t G       = 4'd8;
    localparam note_t G_SHARP = 4'd9;
    localparam note_t A       = 4'd10;
    localparam note_t A_SHARP = 4'd11;
    localparam note_t B       = 4'd12;
    localparam note_t HIGH_C  = 4'd13;

    typedef enum logic [1:0] {
        IDLE,
        GATE,
        HOLD
    } play_state_t;

    // Codes at or above the top legal note (including illegal ones) wrap back to OFF.
    function automatic note_t next_note(input note_t n, input note_t max_n);
        return (n >= max_n) ? OFF : n + note_t'(1);
    endfunction

endpackage

// File: rtl/sequencer_track_if.sv
// rtl/sequencer_track_if.sv - control, beat and note-output bundle of the sequencer track
interface sequencer_track_if #(
    parameter int STEP_W = 3,
    parameter int GATE_W = 4
);

    logic                        sequencer_on;
    logic                        toggle;
    logic                        step_next;
    logic                        clear;
    logic                        button_press;
    logic [STEP_W-1:0]           beat;
    logic                        beat_tick;
    logic [GATE_W-1:0]           gate_len;
    logic [sass_pkg::NOTE_W-1:0] note_out;
    logic [STEP_W-1:0]           cursor;
    logic [sass_pkg::NOTE_W-1:0] cursor_note;
    logic                        active;

    modport master (
        output sequencer_on, toggle, step_next, clear, button_press,
        output beat, beat_tick, gate_len,
        input  note_out, cursor, cursor_note, active
    );

    modport slave (
        input  sequencer_on, toggle, step_next, clear, button_press,
        input  beat, beat_tick, gate_len,
        output note_out, cursor, cursor_note, active
    );

endinterface

// File: rtl/sequencer_track_gate_timer.sv
// rtl/sequencer_track_gate_timer.sv - loadable down-counter timing the gate of a played note
module gate_timer #(
    parameter int GATE_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [GATE_W-1:0] value,
    output logic              expire
);

    logic [GATE_W-1:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (count != '0) begin
            count <= count - GATE_W'(1);
        end
    end

    // Last cycle of the gate: the note must drop on the following cycle.
    assign expire = (count == GATE_W'(1));

endmodule

// File: rtl/sequencer_track.sv
// rtl/sequencer_track.sv - one bar of programmable steps with edit cursor and gated/legato playback
module sequencer_track
    import sass_pkg::*;
#(
    parameter int NUM_STEPS = 8,
    parameter int STEP_W    = $clog2(NUM_STEPS),
    parameter int MAX_NOTE  = 13,
    parameter int GATE_W    = 4
) (
    input logic              clk,
    input logic              rst,
    sequencer_track_if.slave bus
);

    note_t             mem [NUM_STEPS];
    logic [STEP_W-1:0] cursor_q;
    play_state_t       state;
    note_t             held;
    note_t             note_q;
    logic              active_q;

    logic [STEP_W:0]   beat_ext;
    note_t             trig_note;
    logic              trig_play;
    logic              gate_load;
    logic              gate_expire;
    logic              keep_playing;

    assign bus.cursor      = cursor_q;
    assign bus.cursor_note = mem[cursor_q];
    assign bus.note_out    = note_q;
    assign bus.active      = active_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                mem[i] <= OFF;
            end
            cursor_q <= '0;
        end else if (bus.sequencer_on) begin
            if (bus.clear) begin
                for (int i = 0; i < NUM_STEPS; i++) begin
                    mem[i] <= OFF;
                end
            end else if (bus.toggle) begin
                mem[cursor_q] <= next_note(mem[cursor_q], note_t'(MAX_NOTE));
            end
            if (bus.step_next) begin
                cursor_q <= (cursor_q == STEP_W'(NUM_STEPS - 1)) ? '0 : cursor_q + STEP_W'(1);
            end
        end
    end

    // Beats beyond the bar play silence; widened compare keeps the range test meaningful.
    assign beat_ext = {1'b0, bus.beat};

    always_comb begin
        trig_note = OFF;
        if (beat_ext < (STEP_W + 1)'(NUM_STEPS)) begin
            trig_note = mem[bus.beat];
        end
        trig_play    = bus.beat_tick && (trig_note != OFF);
        gate_load    = bus.sequencer_on && trig_play && (bus.gate_len != '0);
        keep_playing = !bus.beat_tick &&
                       ((state == HOLD) || ((state == GATE) && !gate_expire));
    end

    gate_timer #(
        .GATE_W (GATE_W)
    ) u_gate_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (gate_load),
        .value  (bus.gate_len),
        .expire (gate_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            held     <= OFF;
            note_q   <= OFF;
            active_q <= 1'b0;
        end else if (!bus.sequencer_on) begin
            state    <= IDLE;
            note_q   <= OFF;
            active_q <= 1'b0;
        end else begin
            if (bus.beat_tick) begin
                if (trig_play) begin
                    held  <= trig_note;
                    state <= (bus.gate_len != '0) ? GATE : HOLD;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    GATE:    if (gate_expire) state <= IDLE;
                    HOLD:    state <= HOLD;
                    default: state <= IDLE;
                endcase
            end

            active_q <= trig_play || keep_playing;

            // Preview of the cursor step overrides whatever the playback is doing.
            if (bus.button_press) begin
                note_q <= mem[cursor_q];
            end else if (trig_play) begin
                note_q <= trig_note;
            end else if (keep_playing) begin
                note_q <= held;
            end else begin
                note_q <= OFF;
            end
        end
    end

endmodule

// File: tb/tb_sequencer_track.sv
// tb/tb_sequencer_track.sv - self-checking bench for sequencer_track against a behavioural model
module tb_sequencer_track;

    localparam int NS   = 8;
    localparam int SW   = 3;
    localparam int GW   = 4;
    localparam int MAXN = 13;

    logic clk = 1'b0;
    logic rst;

    always #50 clk = ~clk;

    sequencer_track_if #(.STEP_W(SW), .GATE_W(GW)) bus ();

    sequencer_track #(
        .NUM_STEPS (NS),
        .STEP_W    (SW),
        .MAX_NOTE  (MAXN),
        .GATE_W    (GW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    // Model: the bar as an array, and playback as "note + cycles left to sound" (-1 = legato).
    logic [3:0] m_mem [NS];
    int         m_cursor;
    bit         m_play;
    logic [3:0] m_note;
    int         m_left;
    logic [3:0] exp_note;
    bit         exp_active;

    task automatic reset_model();
        for (int i = 0; i < NS; i++) m_mem[i] = 4'd0;
        m_cursor   = 0;
        m_play     = 0;
        m_note     = 4'd0;
        m_left     = 0;
        exp_note   = 4'd0;
        exp_active = 0;
    endtask

    task automatic model_update();
        logic [3:0] n;
        if (bus.sequencer_on) begin
            n = (int'(bus.beat) < NS) ? m_mem[bus.beat] : 4'd0;
            if (bus.beat_tick) begin
                if (n == 4'd0) begin
                    m_play = 0;
                end else begin
                    m_play = 1;
                    m_note = n;
                    m_left = (bus.gate_len == 0) ? -1 : int'(bus.gate_len);
                end
            end else if (m_play && m_left > 0) begin
                m_left--;
                if (m_left == 0) m_play = 0;
            end
            exp_note = bus.button_press ? m_mem[m_cursor] : (m_play ? m_note : 4'd0);
            if (bus.clear) begin
                for (int i = 0; i < NS; i++) m_mem[i] = 4'd0;
            end else if (bus.toggle) begin
                m_mem[m_cursor] = (m_mem[m_cursor] >= 4'(MAXN)) ? 4'd0 : m_mem[m_cursor] + 4'd1;
            end
            if (bus.step_next) m_cursor = (m_cursor + 1) % NS;
        end else begin
            m_play   = 0;
            exp_note = 4'd0;
        end
        exp_active = m_play;
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        bus.toggle    = 1'b0;
        bus.step_next = 1'b0;
        bus.clear     = 1'b0;
        bus.beat_tick = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        tests++;
        if (bus.note_out !== 4'd0) begin
            fails++; $display("FAIL reset_note got %0d want 0", bus.note_out);
        end
        tests++;
        if (bus.active !== 1'b0) begin
            fails++; $display("FAIL reset_active got %0b want 0", bus.active);
        end
        tests++;
        if (bus.cursor !== 3'd0) begin
            fails++; $display("FAIL reset_cursor got %0d want 0", bus.cursor);
        end
        tests++;
        if (bus.cursor_note !== 4'd0) begin
            fails++; $display("FAIL reset_cursor_note got %0d want 0", bus.cursor_note);
        end
        rst = 1'b0;
        reset_model();
    endtask

    task automatic test_gate();
        logic [3:0] want;
        bus.sequencer_on = 1'b1;
        repeat (3) begin
            bus.toggle = 1'b1;
            step();
        end
        bus.beat      = 3'd0;
        bus.gate_len  = 4'd4;
        bus.beat_tick = 1'b1;
        step();
        for (int k = 1; k <= 6; k++) begin
            want = (k <= 4) ? 4'd3 : 4'd0;
            tests++;
            if (bus.note_out !== want) begin
                fails++; $display("FAIL gate_note k=%0d got %0d want %0d", k, bus.note_out, want);
            end
            tests++;
            if (bus.active !== (k <= 4)) begin
                fails++; $display("FAIL gate_active k=%0d got %0b want %0b", k, bus.active, k <= 4);
            end
            step();
        end
    endtask

    task automatic test_wrap();
        logic [3:0] want;
        logic [2:0] wcur;
        repeat (2) begin
            bus.step_next = 1'b1;
            step();
        end
        for (int i = 1; i <= 14; i++) begin
            bus.toggle = 1'b1;
            step();
            want = 4'(i % 14);
            tests++;
            if (bus.cursor_note !== want) begin
                fails++; $display("FAIL wrap_note i=%0d got %0d want %0d", i, bus.cursor_note, want);
            end
        end
        for (int i = 1; i <= 8; i++) begin
            bus.step_next = 1'b1;
            step();
            wcur = 3'((2 + i) % NS);
            tests++;
            if (bus.cursor !== wcur) begin
                fails++; $display("FAIL wrap_cursor i=%0d got %0d want %0d", i, bus.cursor, wcur);
            end
        end
    endtask

    task automatic test_legato();
        repeat (3) begin
            bus.step_next = 1'b1;
            step();
        end
        repeat (7) begin
            bus.toggle = 1'b1;
            step();
        end
        bus.gate_len  = 4'd0;
        bus.beat      = 3'd5;
        bus.beat_tick = 1'b1;
        step();
        for (int k = 1; k <= 20; k++) begin
            tests++;
            if (bus.note_out !== 4'd7) begin
                fails++; $display("FAIL legato_note k=%0d got %0d want 7", k, bus.note_out);
            end
            step();
        end
        bus.beat      = 3'd6;
        bus.beat_tick = 1'b1;
        tests++;
        if (bus.note_out !== 4'd7) begin
            fails++; $display("FAIL legato_before_tick got %0d want 7", bus.note_out);
        end
        step();
        tests++;
        if (bus.note_out !== 4'd0 || bus.active !== 1'b0) begin
            fails++; $display("FAIL legato_end got %0d/%0b want 0/0", bus.note_out, bus.active);
        end
    endtask

    task automatic test_retrigger();
        logic [3:0] want;
        bus.step_next = 1'b1;
        step();
        repeat (9) begin
            bus.toggle = 1'b1;
            step();
        end
        bus.gate_len  = 4'd6;
        bus.beat      = 3'd5;
        bus.beat_tick = 1'b1;
        step();
        for (int k = 1; k <= 10; k++) begin
            want = (k <= 3) ? 4'd7 : (k <= 9) ? 4'd9 : 4'd0;
            tests++;
            if (bus.note_out !== want) begin
                fails++; $display("FAIL retrig_note k=%0d got %0d want %0d", k, bus.note_out, want);
            end
            if (k == 3) begin
                bus.beat      = 3'd6;
                bus.beat_tick = 1'b1;
            end
            if (k == 5) bus.gate_len = 4'd1;
            step();
        end
    endtask

    task automatic test_clear_button();
        logic [3:0] want;
        bus.clear  = 1'b1;
        bus.toggle = 1'b1;
        step();
        for (int i = 0; i < NS; i++) begin
            tests++;
            if (bus.cursor_note !== 4'd0) begin
                fails++; $display("FAIL clear_step cursor=%0d got %0d want 0", bus.cursor, bus.cursor_note);
            end
            bus.step_next = 1'b1;
            step();
        end
        repeat (4) begin
            bus.toggle = 1'b1;
            step();
        end
        bus.step_next = 1'b1;
        step();
        repeat (2) begin
            bus.toggle = 1'b1;
            step();
        end
        repeat (7) begin
            bus.step_next = 1'b1;
            step();
        end
        bus.gate_len  = 4'd8;
        bus.beat      = 3'd7;
        bus.beat_tick = 1'b1;
        step();
        for (int k = 1; k <= 6; k++) begin
            want = (k >= 2 && k <= 4) ? 4'd4 : 4'd2;
            tests++;
            if (bus.note_out !== want) begin
                fails++; $display("FAIL button_note k=%0d got %0d want %0d", k, bus.note_out, want);
            end
            bus.button_press = (k <= 3);
            step();
        end
        bus.button_press = 1'b0;
    endtask

    task automatic test_disable_reset();
        bus.gate_len  = 4'd8;
        bus.beat      = 3'd7;
        bus.beat_tick = 1'b1;
        step();
        tests++;
        if (bus.note_out !== 4'd2) begin
            fails++; $display("FAIL dis_pre got %0d want 2", bus.note_out);
        end
        bus.sequencer_on = 1'b0;
        bus.toggle       = 1'b1;
        step();
        tests++;
        if (bus.note_out !== 4'd0 || bus.active !== 1'b0) begin
            fails++; $display("FAIL dis_off got %0d/%0b want 0/0", bus.note_out, bus.active);
        end
        bus.button_press = 1'b1;
        step();
        bus.button_press = 1'b0;
        tests++;
        if (bus.note_out !== 4'd0) begin
            fails++; $display("FAIL dis_button got %0d want 0", bus.note_out);
        end
        bus.sequencer_on = 1'b1;
        tests++;
        if (bus.cursor_note !== 4'd4 || bus.cursor !== 3'd6) begin
            fails++; $display("FAIL dis_retained got %0d@%0d want 4@6", bus.cursor_note, bus.cursor);
        end
        bus.beat_tick = 1'b1;
        step();
        tests++;
        if (bus.note_out !== 4'd2) begin
            fails++; $display("FAIL reen_note got %0d want 2", bus.note_out);
        end
        rst = 1'b1;
        #1;
        tests++;
        if (bus.note_out !== 4'd0 || bus.active !== 1'b0) begin
            fails++; $display("FAIL async_rst got %0d/%0b want 0/0", bus.note_out, bus.active);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        reset_model();
        for (int i = 0; i < NS; i++) begin
            tests++;
            if (bus.cursor_note !== 4'd0 || bus.cursor !== 3'(i)) begin
                fails++; $display("FAIL rst_steps i=%0d got %0d@%0d want 0@%0d", i, bus.cursor_note, bus.cursor, i);
            end
            bus.step_next = 1'b1;
            step();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            bus.sequencer_on = ($urandom_range(0, 19) != 0);
            bus.toggle       = ($urandom_range(0, 3) == 0);
            bus.step_next    = ($urandom_range(0, 4) == 0);
            bus.clear        = ($urandom_range(0, 39) == 0);
            bus.button_press = ($urandom_range(0, 7) == 0);
            bus.beat_tick    = ($urandom_range(0, 5) == 0);
            bus.beat         = 3'($urandom_range(0, NS - 1));
            bus.gate_len     = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            step();
            tests++;
            if (bus.note_out !== exp_note) begin
                fails++; $display("FAIL rand_note c=%0d got %0d want %0d", c, bus.note_out, exp_note);
            end
            tests++;
            if (bus.active !== exp_active) begin
                fails++; $display("FAIL rand_active c=%0d got %0b want %0b", c, bus.active, exp_active);
            end
            tests++;
            if (bus.cursor !== 3'(m_cursor)) begin
                fails++; $display("FAIL rand_cursor c=%0d got %0d want %0d", c, bus.cursor, m_cursor);
            end
            tests++;
            if (bus.cursor_note !== m_mem[m_cursor]) begin
                fails++; $display("FAIL rand_cursor_note c=%0d got %0d want %0d", c, bus.cursor_note, m_mem[m_cursor]);
            end
        end
        bus.button_press = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus.sequencer_on = 1'b0;
        bus.toggle       = 1'b0;
        bus.step_next    = 1'b0;
        bus.clear        = 1'b0;
        bus.button_press = 1'b0;
        bus.beat         = 3'd0;
        bus.beat_tick    = 1'b0;
        bus.gate_len     = 4'd0;
        reset_model();

        test_reset();
        test_gate();
        test_wrap();
        test_legato();
        test_retrigger();
        test_clear_button();
        test_disable_reset();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
